// File: rtl/cs_seq_pkg.sv
// Shared constants for the control-store REP micro-sequencer: state encodings,
// default geometry and the uop-index width helper.
package cs_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ISSUE = 2'b01;
    localparam logic [1:0] ST_SKIP  = 2'b10;

    localparam int CS_AW_DEF    = 8;
    localparam int MAX_UOPS_DEF = 4;
    localparam int CNT_W_DEF    = 32;

    // Bits needed to index 0..max_uops-1, never less than one.
    function automatic int uop_idx_w(input int max_uops);
        return (max_uops > 1) ? $clog2(max_uops) : 1;
    endfunction

endpackage

// File: rtl/cs_seq_counter.sv
// Loadable down-counter holding the remaining REP iteration count (ECX image).
module cs_seq_counter
    import cs_seq_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         is_one_o,
    output logic         is_zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign is_one_o  = (count_q == W'(1));
    assign is_zero_o = (count_q == '0);

endmodule

// File: rtl/cs_rep_sequencer.sv
// Issues control-store row addresses for one decoded instruction, repeating the uop
// group for REP. Optional iteration statistics enabled by defining CS_SEQ_STATS_EN.
module cs_rep_sequencer
    import cs_seq_pkg::*;
#(
    parameter int CS_AW    = CS_AW_DEF,
    parameter int MAX_UOPS = MAX_UOPS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CS_AW-1:0]           in_base_addr,
    input  logic [$clog2(MAX_UOPS):0]  in_nuops,
    input  logic                       in_isREP,
    input  logic [CNT_W-1:0]           in_count,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CS_AW-1:0]           out_cs_addr,
    output logic                       out_nop,
    output logic                       out_last,
    output logic                       out_iter_end,
    output logic [CNT_W-1:0]           out_remaining,
    output logic                       busy,
    output logic [31:0]                perf_iters
);

    localparam int NW = $clog2(MAX_UOPS) + 1;
    localparam int IW = uop_idx_w(MAX_UOPS);

    logic [1:0]       state_q, state_d;
    logic [CS_AW-1:0] base_q, base_d;
    logic [NW-1:0]    nuops_q, nuops_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NW-1:0]    nuops_clamped;

    logic             cnt_load, cnt_dec;
    logic [CNT_W-1:0] cnt_load_val, cnt_val;
    logic             cnt_is_one, cnt_is_zero;

    logic             in_fire, out_fire, grp_end;

    cs_seq_counter #(.W(CNT_W)) u_count (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt_val),
        .is_one_o   (cnt_is_one),
        .is_zero_o  (cnt_is_zero)
    );

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign grp_end  = (state_q == ST_ISSUE) && (NW'(idx_q) == nuops_q - NW'(1));

    // Zero-length groups still issue one uop; oversize groups saturate.
    assign nuops_clamped = (in_nuops == '0)             ? NW'(1) :
                           (in_nuops > NW'(MAX_UOPS))   ? NW'(MAX_UOPS) : in_nuops;

    assign cnt_load_val = in_isREP ? in_count : CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        nuops_d  = nuops_q;
        idx_d    = idx_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_fire) begin
                        base_d   = in_base_addr;
                        nuops_d  = nuops_clamped;
                        idx_d    = '0;
                        cnt_load = 1'b1;
                        state_d  = (in_isREP && (in_count == '0)) ? ST_SKIP : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (out_fire) begin
                        if (!grp_end) begin
                            idx_d = idx_q + IW'(1);
                        end else if (!cnt_is_one && !cnt_is_zero) begin
                            cnt_dec = 1'b1;
                            idx_d   = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_SKIP: begin
                    if (out_fire) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            nuops_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            nuops_q <= nuops_d;
            idx_q   <= idx_d;
        end
    end

    // Data outputs are forced to zero whenever nothing is being presented.
    assign in_ready      = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign out_valid     = (state_q == ST_ISSUE) || (state_q == ST_SKIP);
    assign out_cs_addr   = out_valid ? (base_q + CS_AW'(idx_q)) : '0;
    assign out_nop       = (state_q == ST_SKIP);
    assign out_iter_end  = grp_end;
    assign out_last      = (state_q == ST_SKIP) || (grp_end && cnt_is_one);
    assign out_remaining = out_valid ? cnt_val : '0;

`ifdef CS_SEQ_STATS_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (!flush && out_fire && grp_end) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_iters = perf_q;
`else
    assign perf_iters = '0;
`endif

endmodule
